// File: rtl/sample_display_sched.sv
// sample_display_sched
// Shares one 32-bit debug display word between NUM_CH microphone sample streams.
// Each channel's latest sample, its peak magnitude and a "seen" flag are latched on its
// data_rdy strobe. The displayed channel either rotates on a dwell timer (auto/peak) or
// follows man_ch (manual).
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   data        NUM_CH packed samples, channel i at [i*DATA_W +: DATA_W]
//   data_rdy    per-channel one-cycle sample strobe
//   mode_sel    0 auto, 1 manual, 2 peak, 3 reserved (behaves as auto)
//   man_ch      channel shown in manual mode (ignored if >= NUM_CH)
//   advance     pulse: step to the next channel (auto/peak only)
//   clear_peak  pulse: zero all peak registers
//   disp_val    {channel[3:0], mode[3:0], zero pad, value[DATA_W-1:0]}
//   disp_ch     channel currently displayed
//   disp_valid  displayed channel has captured a sample since reset
module sample_display_sched #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = 18,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic [NUM_CH-1:0]        data_rdy,
  input  logic [1:0]               mode_sel,
  input  logic [2:0]               man_ch,
  input  logic                     advance,
  input  logic                     clear_peak,
  output logic [31:0]              disp_val,
  output logic [2:0]               disp_ch,
  output logic                     disp_valid
);

  // Storage is sized for the largest legal channel count so a 3-bit channel index never
  // selects out of range; entries above NUM_CH never see a strobe and stay zero.
  localparam int unsigned MaxCh   = 8;
  localparam int unsigned CntW    = $clog2(DWELL_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [2:0] LastCh   = 3'(NUM_CH - 1);
  localparam logic [3:0] NumCh4   = 4'(NUM_CH);

  localparam logic [0:0] StWait = 1'b0;
  localparam logic [0:0] StShow = 1'b1;

  localparam logic [1:0] ModeManual = 2'd1;
  localparam logic [1:0] ModePeak   = 2'd2;

  // Magnitude in DATA_W bits; the most negative input saturates to the largest positive.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    if (!x[DATA_W-1]) return x;
    if (x[DATA_W-2:0] == '0) return {1'b0, {(DATA_W-1){1'b1}}};
    return -x;
  endfunction

  logic [MaxCh*DATA_W-1:0] data_pad;
  logic [MaxCh-1:0]        rdy;
  logic [DATA_W-1:0]       slice     [MaxCh];
  logic [DATA_W-1:0]       slice_mag [MaxCh];

  assign data_pad = (MaxCh*DATA_W)'(data);
  assign rdy      = MaxCh'(data_rdy);

  always_comb begin
    for (int i = 0; i < MaxCh; i++) begin
      slice[i]     = data_pad[i*DATA_W +: DATA_W];
      slice_mag[i] = mag(data_pad[i*DATA_W +: DATA_W]);
    end
  end

  // Per-channel capture
  logic [DATA_W-1:0] sample_q [MaxCh];
  logic [DATA_W-1:0] peak_q   [MaxCh];
  logic [MaxCh-1:0]  seen_q;
  logic [MaxCh-1:0]  seen_d;

  assign seen_d = seen_q | rdy;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MaxCh; i++) begin
        sample_q[i] <= '0;
        peak_q[i]   <= '0;
      end
      seen_q <= '0;
    end else begin
      for (int i = 0; i < MaxCh; i++) begin
        if (rdy[i]) begin
          sample_q[i] <= slice[i];
          // A coincident clear restarts the peak from this sample rather than zero.
          if (clear_peak || (slice_mag[i] > peak_q[i])) peak_q[i] <= slice_mag[i];
        end else if (clear_peak) begin
          peak_q[i] <= '0;
        end
      end
      seen_q <= seen_d;
    end
  end

  // Channel selection and WAIT/SHOW state
  logic [2:0]      cur_ch_q, cur_ch_d, next_ch;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [0:0]      state_q, state_d;

  always_comb begin
    next_ch  = (cur_ch_q == LastCh) ? 3'd0 : cur_ch_q + 3'd1;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    if (mode_sel == ModeManual) begin
      cnt_d = '0;
      if ({1'b0, man_ch} < NumCh4) cur_ch_d = man_ch;
    end else if (advance || (cnt_q == CntLast)) begin
      // Advance and dwell expiry together still move a single step.
      cur_ch_d = next_ch;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Looking at seen_d lets a strobe on the incoming channel count on the switch edge.
    state_d = seen_d[cur_ch_d] ? StShow : StWait;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_ch_q <= '0;
      cnt_q    <= '0;
      state_q  <= StWait;
    end else begin
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // Registered display outputs
  logic [31:0] disp_val_d;

  always_comb begin
    disp_val_d        = '0;
    disp_val_d[31:28] = {1'b0, cur_ch_q};
    disp_val_d[27:24] = {2'b00, mode_sel};
    if (state_q == StShow) begin
      disp_val_d[DATA_W-1:0] = (mode_sel == ModePeak) ? peak_q[cur_ch_q] : sample_q[cur_ch_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      disp_val   <= '0;
      disp_ch    <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_val   <= disp_val_d;
      disp_ch    <= cur_ch_q;
      disp_valid <= (state_q == StShow);
    end
  end

endmodule

// File: tb/tb_sample_display_sched.sv
// Directed testbench for sample_display_sched with a short dwell (8 cycles).
module tb_sample_display_sched;

  localparam int unsigned NumCh = 4;
  localparam int unsigned DataW = 18;
  localparam int unsigned Dwell = 8;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NumCh*DataW-1:0]  data;
  logic [NumCh-1:0]        data_rdy;
  logic [1:0]              mode_sel;
  logic [2:0]              man_ch;
  logic                    advance;
  logic                    clear_peak;
  logic [31:0]             disp_val;
  logic [2:0]              disp_ch;
  logic                    disp_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sample_display_sched #(
    .NUM_CH      (NumCh),
    .DATA_W      (DataW),
    .DWELL_CYCLES(Dwell)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .data_rdy  (data_rdy),
    .mode_sel  (mode_sel),
    .man_ch    (man_ch),
    .advance   (advance),
    .clear_peak(clear_peak),
    .disp_val  (disp_val),
    .disp_ch   (disp_ch),
    .disp_valid(disp_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_strobes();
    data_rdy   = '0;
    advance    = 1'b0;
    clear_peak = 1'b0;
  endtask

  task automatic set_sample(input int ch, input logic [DataW-1:0] v);
    data[ch*DataW +: DataW] = v;
    data_rdy[ch]            = 1'b1;
  endtask

  // Leaves the bench just after the reset edge (called E0 below).
  task automatic do_reset();
    reset    = 1'b1;
    mode_sel = 2'd0;
    man_ch   = 3'd0;
    data     = '0;
    idle_strobes();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    data  = '0;
    mode_sel = 2'd0;
    man_ch = 3'd0;
    idle_strobes();

    // Reset state and idle rotation
    do_reset();
    check_eq("rst_val", disp_val, 32'h0);
    check_eq("rst_ch", 32'(disp_ch), 32'd0);
    check_eq("rst_valid", 32'(disp_valid), 32'd0);
    for (int k = 1; k <= 33; k++) begin
      tick();
      check_eq("idle_ch", 32'(disp_ch), 32'(((k - 1) / 8) % 4));
      check_eq("idle_valid", 32'(disp_valid), 32'd0);
      check_eq("idle_value", 32'(disp_val[DataW-1:0]), 32'd0);
    end

    // Auto capture on channel 0, then empty channel 1
    do_reset();
    set_sample(0, 18'h00123);
    tick();                                   // E1: captured
    idle_strobes();
    check_eq("cap_latency_valid", 32'(disp_valid), 32'd0);
    tick();                                   // E2: visible
    check_eq("cap_val", disp_val, 32'h0000_0123);
    check_eq("cap_valid", 32'(disp_valid), 32'd1);
    ticks(7);                                 // E9: channel 1 displayed
    check_eq("ch1_ch", 32'(disp_ch), 32'd1);
    check_eq("ch1_valid", 32'(disp_valid), 32'd0);

    // Manual mode
    do_reset();
    mode_sel = 2'd1;
    man_ch   = 3'd2;
    set_sample(2, 18'h3FFFF);
    tick();
    idle_strobes();
    tick();
    check_eq("man_val", disp_val, 32'h2103_FFFF);
    check_eq("man_valid", 32'(disp_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      ticks(10);
      check_eq("man_hold_ch", 32'(disp_ch), 32'd2);
    end
    man_ch = 3'd5;
    ticks(3);
    check_eq("man_oob_ch", 32'(disp_ch), 32'd2);
    check_eq("man_oob_val", disp_val, 32'h2103_FFFF);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    ticks(2);
    check_eq("man_adv_ignored", 32'(disp_ch), 32'd2);

    // Peak tracking and clear
    do_reset();
    set_sample(0, 18'd5);
    set_sample(1, 18'd50);
    tick();                                   // E1
    idle_strobes();
    set_sample(0, 18'h3FF38);                 // -200
    tick();                                   // E2
    set_sample(0, 18'h20000);                 // most negative
    tick();                                   // E3
    set_sample(0, 18'd7);
    tick();                                   // E4
    check_eq("auto_sample_val", disp_val, 32'h0002_0000);
    idle_strobes();
    mode_sel = 2'd2;
    tick();                                   // E5
    check_eq("peak_val", disp_val, 32'h0201_FFFF);
    clear_peak = 1'b1;
    set_sample(0, 18'd3);
    tick();                                   // E6
    idle_strobes();
    tick();                                   // E7
    check_eq("peak_clear_coincident", disp_val, 32'h0200_0003);
    ticks(2);                                 // E9: channel 1
    check_eq("peak_clear_other", disp_val, 32'h1200_0000);
    check_eq("peak_other_valid", 32'(disp_valid), 32'd1);

    // Advance against dwell expiry
    do_reset();
    ticks(31);                                // E31: ch3, counter at last count
    check_eq("adv_pre_ch", 32'(disp_ch), 32'd3);
    advance = 1'b1;
    tick();                                   // E32
    advance = 1'b0;
    tick();                                   // E33
    check_eq("adv_coincide_ch", 32'(disp_ch), 32'd0);
    ticks(2);                                 // E35
    advance = 1'b1;
    tick();                                   // E36
    advance = 1'b0;
    check_eq("adv_mid_before", 32'(disp_ch), 32'd0);
    tick();                                   // E37
    check_eq("adv_mid_ch", 32'(disp_ch), 32'd1);
    ticks(7);                                 // E44
    check_eq("adv_restart_hold", 32'(disp_ch), 32'd1);
    tick();                                   // E45
    check_eq("adv_restart_next", 32'(disp_ch), 32'd2);

    // Reset in the middle of a peak-mode dwell
    do_reset();
    mode_sel = 2'd2;
    set_sample(0, 18'd9);
    tick();                                   // E1
    idle_strobes();
    tick();                                   // E2
    check_eq("pre_rst_val", disp_val, 32'h0200_0009);
    tick();                                   // E3
    reset = 1'b1;
    set_sample(0, 18'd11);                    // dropped by reset
    tick();                                   // E4
    reset = 1'b0;
    idle_strobes();
    check_eq("midrst_val", disp_val, 32'h0);
    check_eq("midrst_ch", 32'(disp_ch), 32'd0);
    check_eq("midrst_valid", 32'(disp_valid), 32'd0);
    tick();                                   // E5
    check_eq("post_rst_val", disp_val, 32'h0200_0000);
    check_eq("post_rst_valid", 32'(disp_valid), 32'd0);
    ticks(2);
    check_eq("post_rst_still_invalid", 32'(disp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
